// File: rtl/ucsbece154a_mc_controller_if.sv
// Memory handshake bundle between the multicycle controller and the unified memory.
// The controller drives through the master modport and the memory answers through the slave modport.
interface ucsbece154a_mc_controller_if;
    logic mem_req_o;
    logic mem_ready_i;
    logic MemWrite_o;
    logic AdrSrc_o;

    modport master (
        output mem_req_o,
        output MemWrite_o,
        output AdrSrc_o,
        input  mem_ready_i
    );

    modport slave (
        input  mem_req_o,
        input  MemWrite_o,
        input  AdrSrc_o,
        output mem_ready_i
    );
endinterface

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle RV32I control unit: a Moore FSM with a variable-latency memory handshake and a retired-instruction counter.
// Define UCSBECE154A_BNE_EN to decode bne; otherwise every branch opcode is treated as beq.
module ucsbece154a_mc_controller #(
    parameter int ALUCTRL_W = 3,
    parameter int IMMSRC_W  = 3,
    parameter int RETIRE_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    ucsbece154a_mc_controller_if.master mem,
    input  logic [6:0]                op_i,
    input  logic [2:0]                funct3_i,
    input  logic                      funct7b5_i,
    input  logic                      zero_i,
    output logic                      PCWrite_o,
    output logic                      IRWrite_o,
    output logic                      RegWrite_o,
    output logic [1:0]                ResultSrc_o,
    output logic [1:0]                ALUSrcA_o,
    output logic [1:0]                ALUSrcB_o,
    output logic [IMMSRC_W-1:0]       ImmSrc_o,
    output logic [ALUCTRL_W-1:0]      ALUControl_o,
    output logic                      illegal_o,
    output logic [RETIRE_W-1:0]       instret_o
);

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_JAL,
        S_ALUWB,
        S_BRANCH
    } state_t;

    state_t              state_q, state_d;
    logic [RETIRE_W-1:0] instret_q, instret_d;

    logic       memReq;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic       pcUpdate;
    logic       branch;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] srcA;
    logic [1:0] srcB;
    logic [2:0] immSrc;
    logic [1:0] aluOp;
    logic       decodeIllegal;
    logic       retire;

    logic [2:0] aluCtl;
    logic       aluIllegal;
    logic       takeBranch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        memReq        = 1'b0;
        adrSrc        = 1'b0;
        memWrite      = 1'b0;
        irWrite       = 1'b0;
        pcUpdate      = 1'b0;
        branch        = 1'b0;
        regWrite      = 1'b0;
        resultSrc     = 2'b00;
        srcA          = 2'b00;
        srcB          = 2'b00;
        immSrc        = 3'b000;
        aluOp         = 2'b00;
        decodeIllegal = 1'b0;
        retire        = 1'b0;

        case (state_q)
            S_FETCH: begin
                memReq    = 1'b1;
                srcB      = 2'b10;
                resultSrc = 2'b10;
                irWrite   = mem.mem_ready_i;
                pcUpdate  = mem.mem_ready_i;
                if (mem.mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                srcA   = 2'b01;
                srcB   = 2'b01;
                immSrc = (op_i == OP_JAL) ? 3'b011 : 3'b010;
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI;
                    OP_BRANCH: begin
`ifdef UCSBECE154A_BNE_EN
                        if (funct3_i == 3'b000 || funct3_i == 3'b001) begin
                            state_d = S_BRANCH;
                        end else begin
                            decodeIllegal = 1'b1;
                            state_d       = S_FETCH;
                        end
`else
                        state_d = S_BRANCH;
`endif
                    end
                    default: begin
                        decodeIllegal = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                srcA    = 2'b10;
                srcB    = 2'b01;
                immSrc  = (op_i == OP_SW) ? 3'b001 : 3'b000;
                state_d = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
                if (mem.mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                adrSrc   = 1'b1;
                if (mem.mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                srcA    = 2'b10;
                aluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                srcA    = 2'b10;
                srcB    = 2'b01;
                aluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                srcA    = 2'b11;
                srcB    = 2'b01;
                immSrc  = 3'b100;
                state_d = S_ALUWB;
            end
            S_JAL: begin
                srcA     = 2'b01;
                srcB     = 2'b10;
                pcUpdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                srcA    = 2'b10;
                aluOp   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // funct3 values outside add/sub/slt/or/and fall back to add and raise illegal_o,
    // but the instruction still completes its writeback.
    always_comb begin
        aluCtl     = 3'b000;
        aluIllegal = 1'b0;
        case (aluOp)
            2'b00: aluCtl = 3'b000;
            2'b01: aluCtl = 3'b001;
            2'b10: begin
                case (funct3_i)
                    3'b000:  aluCtl = (funct7b5_i & op_i[5]) ? 3'b001 : 3'b000;
                    3'b010:  aluCtl = 3'b101;
                    3'b110:  aluCtl = 3'b011;
                    3'b111:  aluCtl = 3'b010;
                    default: begin
                        aluCtl     = 3'b000;
                        aluIllegal = 1'b1;
                    end
                endcase
            end
            default: aluCtl = 3'b000;
        endcase
    end

    always_comb begin
`ifdef UCSBECE154A_BNE_EN
        takeBranch = (funct3_i == 3'b001) ? ~zero_i : zero_i;
`else
        takeBranch = zero_i;
`endif
    end

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + RETIRE_W'(1);
    end

    // Reset overrides every enable combinationally so an aborted instruction writes nothing.
    assign mem.mem_req_o  = memReq & ~reset;
    assign mem.MemWrite_o = memWrite & ~reset;
    assign mem.AdrSrc_o   = adrSrc;
    assign PCWrite_o      = (pcUpdate | (branch & takeBranch)) & ~reset;
    assign IRWrite_o      = irWrite & ~reset;
    assign RegWrite_o     = regWrite & ~reset;
    assign ResultSrc_o    = resultSrc;
    assign ALUSrcA_o      = srcA;
    assign ALUSrcB_o      = srcB;
    assign ImmSrc_o       = IMMSRC_W'(immSrc);
    assign ALUControl_o   = ALUCTRL_W'(aluCtl);
    assign illegal_o      = (decodeIllegal | aluIllegal) & ~reset;
    assign instret_o      = instret_q;

endmodule
